// File: rtl/obj_sprite_engine.sv
// Runtime-configurable sprite slots with double-buffered config, committed at frame start.
// Two-stage pipeline: per-slot hit/offset capture, then priority select and sheet address.
module obj_sprite_engine #(
    parameter int N_OBJ        = 4,
    parameter int OBJ_W        = 10,
    parameter int OBJ_H        = 10,
    parameter int SHEET_W      = 360,
    parameter int SHEET_SIZE   = 86400,
    parameter int ADDR_W       = 17,
    parameter int BLINK_FRAMES = 16,
    localparam int IDX_W       = (N_OBJ > 1) ? $clog2(N_OBJ) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [9:0]        h_cnt,
    input  logic [9:0]        v_cnt,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic              cfg_en,
    input  logic              cfg_blink,
    input  logic [8:0]        cfg_x,
    input  logic [8:0]        cfg_y,
    input  logic [8:0]        cfg_sx,
    input  logic [8:0]        cfg_sy,
    output logic              frame_start,
    output logic [ADDR_W-1:0] pixel_addr,
    output logic              isObject,
    output logic [IDX_W-1:0]  obj_id
);

    localparam int FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [9:0] w_x;
    logic [9:0] w_y;
    logic       w_fs_raw;
    logic       w_idx_ok;

    logic       r_fs_prev;
    logic [FCNT_W-1:0] r_fcnt;
    logic       r_phase;

    logic       r_sh_en    [N_OBJ];
    logic       r_sh_blink [N_OBJ];
    logic [8:0] r_sh_x     [N_OBJ];
    logic [8:0] r_sh_y     [N_OBJ];
    logic [8:0] r_sh_sx    [N_OBJ];
    logic [8:0] r_sh_sy    [N_OBJ];

    logic       r_act_en    [N_OBJ];
    logic       r_act_blink [N_OBJ];
    logic [8:0] r_act_x     [N_OBJ];
    logic [8:0] r_act_y     [N_OBJ];
    logic [8:0] r_act_sx    [N_OBJ];
    logic [8:0] r_act_sy    [N_OBJ];

    logic       w_hit [N_OBJ];
    logic [9:0] w_row [N_OBJ];
    logic [9:0] w_col [N_OBJ];
    logic       r_hit [N_OBJ];
    logic [9:0] r_row [N_OBJ];
    logic [9:0] r_col [N_OBJ];

    logic             w_sel_hit;
    logic [IDX_W-1:0] w_sel_id;
    logic [9:0]       w_sel_row;
    logic [9:0]       w_sel_col;
    logic [31:0]      w_addr_full;
    logic [31:0]      w_addr_wrap;

    assign w_x      = h_cnt >> 1;
    assign w_y      = v_cnt >> 1;
    assign w_fs_raw = (h_cnt == '0) && (v_cnt == '0);
    assign w_idx_ok = int'(cfg_idx) < N_OBJ;

    // Commit copies the shadow value held before this edge, so a same-cycle write waits a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fs_prev   <= 1'b0;
            frame_start <= 1'b0;
            r_fcnt      <= '0;
            r_phase     <= 1'b0;
            for (int unsigned i = 0; i < N_OBJ; i++) begin
                r_sh_en[i]     <= 1'b0;
                r_sh_blink[i]  <= 1'b0;
                r_sh_x[i]      <= '0;
                r_sh_y[i]      <= '0;
                r_sh_sx[i]     <= '0;
                r_sh_sy[i]     <= '0;
                r_act_en[i]    <= 1'b0;
                r_act_blink[i] <= 1'b0;
                r_act_x[i]     <= '0;
                r_act_y[i]     <= '0;
                r_act_sx[i]    <= '0;
                r_act_sy[i]    <= '0;
            end
        end else begin
            r_fs_prev   <= w_fs_raw;
            frame_start <= w_fs_raw & ~r_fs_prev;
            if (frame_start) begin
                for (int unsigned i = 0; i < N_OBJ; i++) begin
                    r_act_en[i]    <= r_sh_en[i];
                    r_act_blink[i] <= r_sh_blink[i];
                    r_act_x[i]     <= r_sh_x[i];
                    r_act_y[i]     <= r_sh_y[i];
                    r_act_sx[i]    <= r_sh_sx[i];
                    r_act_sy[i]    <= r_sh_sy[i];
                end
                if (r_fcnt == FCNT_W'(BLINK_FRAMES - 1)) begin
                    r_fcnt  <= '0;
                    r_phase <= ~r_phase;
                end else begin
                    r_fcnt <= r_fcnt + 1'b1;
                end
            end
            if (cfg_we && w_idx_ok) begin
                r_sh_en[cfg_idx]    <= cfg_en;
                r_sh_blink[cfg_idx] <= cfg_blink;
                r_sh_x[cfg_idx]     <= cfg_x;
                r_sh_y[cfg_idx]     <= cfg_y;
                r_sh_sx[cfg_idx]    <= cfg_sx;
                r_sh_sy[cfg_idx]    <= cfg_sy;
            end
        end
    end

    // Row/column offsets wrap in 10 bits but are only consumed when the slot hits.
    always_comb begin
        for (int unsigned i = 0; i < N_OBJ; i++) begin
            w_hit[i] = r_act_en[i] && !(r_act_blink[i] && r_phase)
                    && (w_x >= {1'b0, r_act_x[i]}) && (w_x < {1'b0, r_act_x[i]} + 10'(OBJ_W))
                    && (w_y >= {1'b0, r_act_y[i]}) && (w_y < {1'b0, r_act_y[i]} + 10'(OBJ_H));
            w_row[i] = {1'b0, r_act_sy[i]} + (w_y - {1'b0, r_act_y[i]});
            w_col[i] = {1'b0, r_act_sx[i]} + (w_x - {1'b0, r_act_x[i]});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_OBJ; i++) begin
                r_hit[i] <= 1'b0;
                r_row[i] <= '0;
                r_col[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_OBJ; i++) begin
                r_hit[i] <= w_hit[i];
                r_row[i] <= w_row[i];
                r_col[i] <= w_col[i];
            end
        end
    end

    always_comb begin
        w_sel_hit = 1'b0;
        w_sel_id  = '0;
        w_sel_row = '0;
        w_sel_col = '0;
        for (int unsigned i = 0; i < N_OBJ; i++) begin
            if (r_hit[i] && !w_sel_hit) begin
                w_sel_hit = 1'b1;
                w_sel_id  = IDX_W'(i);
                w_sel_row = r_row[i];
                w_sel_col = r_col[i];
            end
        end
        w_addr_full = 32'(w_sel_row) * 32'(SHEET_W) + 32'(w_sel_col);
        w_addr_wrap = (w_addr_full >= 32'(SHEET_SIZE)) ? (w_addr_full - 32'(SHEET_SIZE)) : w_addr_full;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            isObject   <= 1'b0;
            pixel_addr <= '0;
            obj_id     <= '0;
        end else begin
            isObject   <= w_sel_hit;
            pixel_addr <= w_sel_hit ? ADDR_W'(w_addr_wrap) : '0;
            obj_id     <= w_sel_id;
        end
    end

endmodule

// File: tb/tb_obj_sprite_engine.sv
// Bench for obj_sprite_engine: vector table, directed frame sequences, and random
// config/pixel traffic checked against a slot-list model using plain arithmetic.
module tb_obj_sprite_engine;

    localparam int N  = 3;
    localparam int BF = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  h_cnt, v_cnt;
    logic        cfg_we;
    logic [1:0]  cfg_idx;
    logic        cfg_en, cfg_blink;
    logic [8:0]  cfg_x, cfg_y, cfg_sx, cfg_sy;
    logic        frame_start;
    logic [16:0] pixel_addr;
    logic        isObject;
    logic [1:0]  obj_id;

    obj_sprite_engine #(.N_OBJ(N), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .rst_n(rst_n), .h_cnt(h_cnt), .v_cnt(v_cnt),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en), .cfg_blink(cfg_blink),
        .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_sx(cfg_sx), .cfg_sy(cfg_sy),
        .frame_start(frame_start), .pixel_addr(pixel_addr),
        .isObject(isObject), .obj_id(obj_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit en;
        bit bl;
        int x, y, sx, sy;
    } slot_t;

    typedef struct {
        int x, y;
        bit hit;
        int addr;
        int id;
    } vec_t;

    slot_t m_sh[N];
    slot_t m_act[N];
    int    m_k;
    int    tests = 0;
    int    fails = 0;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_sh[i] = '{0, 0, 0, 0, 0, 0};
        m_act = m_sh;
        m_k   = 0;
    endtask

    function automatic void model_px(input int x, input int y,
                                     output bit hit, output int addr, output int id);
        bit phase;
        phase = ((m_k / BF) % 2) == 1;
        hit = 0; addr = 0; id = 0;
        for (int i = 0; i < N; i++) begin
            if (!hit && m_act[i].en && !(m_act[i].bl && phase)
                && x >= m_act[i].x && x < m_act[i].x + 10
                && y >= m_act[i].y && y < m_act[i].y + 10) begin
                hit  = 1;
                id   = i;
                addr = (m_act[i].sy + y - m_act[i].y) * 360 + m_act[i].sx + x - m_act[i].x;
                if (addr >= 86400) addr -= 86400;
            end
        end
    endfunction

    task automatic cfg_write(input int idx, input bit en, input bit bl,
                             input int x, input int y, input int sx, input int sy);
        @(negedge clk);
        cfg_idx = 2'(idx); cfg_en = en; cfg_blink = bl;
        cfg_x = 9'(x); cfg_y = 9'(y); cfg_sx = 9'(sx); cfg_sy = 9'(sy);
        cfg_we = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0;
        if (idx < N) m_sh[idx] = '{en, bl, x, y, sx, sy};
    endtask

    // Holds the counters at the origin for three cycles; optionally writes during the pulse cycle.
    task automatic do_frame(input bit wr, input int idx, input bit en, input bit bl,
                            input int x, input int y, input int sx, input int sy);
        @(negedge clk);
        h_cnt = '0; v_cnt = '0;
        @(negedge clk);
        chk("fs_pulse", int'(frame_start), 1);
        if (wr) begin
            cfg_idx = 2'(idx); cfg_en = en; cfg_blink = bl;
            cfg_x = 9'(x); cfg_y = 9'(y); cfg_sx = 9'(sx); cfg_sy = 9'(sy);
            cfg_we = 1'b1;
        end
        m_act = m_sh;
        m_k++;
        if (wr && idx < N) m_sh[idx] = '{en, bl, x, y, sx, sy};
        @(negedge clk);
        cfg_we = 1'b0;
        chk("fs_single", int'(frame_start), 0);
        @(negedge clk);
        chk("fs_hold", int'(frame_start), 0);
        h_cnt = 10'd1; v_cnt = 10'd1;
    endtask

    task automatic frame();
        do_frame(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_pix(input int x, input int y, input bit ehit,
                             input int eaddr, input int eid, input string nm);
        int h, v;
        @(negedge clk);
        h = 2 * x + int'($urandom_range(0, 1));
        v = 2 * y + int'($urandom_range(0, 1));
        if (h == 0 && v == 0) h = 1;
        h_cnt = 10'(h); v_cnt = 10'(v);
        @(negedge clk);
        @(negedge clk);
        chk({nm, "_hit"},  int'(isObject),   int'(ehit));
        chk({nm, "_addr"}, int'(pixel_addr), eaddr);
        chk({nm, "_id"},   int'(obj_id),     eid);
    endtask

    task automatic check_model(input int x, input int y, input string nm);
        bit hit;
        int addr, id;
        model_px(x, y, hit, addr, id);
        check_pix(x, y, hit, addr, id, nm);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        tbl[0] = '{70, 40, 1, 11120, 0};
        tbl[1] = '{79, 49, 1, 14369, 0};
        tbl[2] = '{80, 40, 0, 0, 0};
        tbl[3] = '{69, 40, 0, 0, 0};
        tbl[4] = '{70, 50, 0, 0, 0};
        tbl[5] = '{75, 45, 1, 12925, 0};

        rst_n = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_en = 1'b0; cfg_blink = 1'b0;
        cfg_x = '0; cfg_y = '0; cfg_sx = '0; cfg_sy = '0;
        h_cnt = 10'd5; v_cnt = 10'd5;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_fs",   int'(frame_start), 0);
        chk("rst_hit",  int'(isObject),    0);
        chk("rst_addr", int'(pixel_addr),  0);
        chk("rst_id",   int'(obj_id),      0);
        rst_n = 1'b1;

        // Before the first commit nothing is visible.
        cfg_write(0, 1, 0, 70, 40, 320, 30);
        check_pix(70, 40, 0, 0, 0, "precommit");
        frame();
        foreach (tbl[i]) check_pix(tbl[i].x, tbl[i].y, tbl[i].hit, tbl[i].addr, tbl[i].id, "tbl");

        // Overlap priority and disable taking effect only at the next frame.
        cfg_write(1, 1, 0, 95, 95, 0, 0);
        cfg_write(2, 1, 0, 100, 100, 10, 20);
        frame();
        check_pix(100, 100, 1, 1805, 1, "overlap");
        cfg_write(1, 0, 0, 95, 95, 0, 0);
        check_pix(100, 100, 1, 1805, 1, "dis_pending");
        frame();
        check_pix(100, 100, 1, 7210, 2, "dis_applied");

        // Double buffer: mid-frame write, then a write in the pulse cycle.
        cfg_write(0, 1, 0, 200, 40, 320, 30);
        check_pix(70, 40, 1, 11120, 0, "db_old");
        check_pix(200, 40, 0, 0, 0, "db_notyet");
        do_frame(1, 0, 1, 0, 300, 40, 320, 30);
        check_pix(200, 40, 1, 11120, 0, "db_new");
        check_pix(300, 40, 0, 0, 0, "db_fs_wr_wait");
        frame();
        check_pix(300, 40, 1, 11120, 0, "db_fs_wr");
        check_pix(200, 40, 0, 0, 0, "db_fs_old");

        // Blink on slot2; slot0 stays steady.
        cfg_write(2, 1, 1, 100, 100, 10, 20);
        for (int f = 0; f < 6; f++) begin
            frame();
            check_model(100, 100, "blink");
            check_pix(300, 40, 1, 11120, 0, "steady");
        end

        // Address wrap and out-of-range slot index.
        cfg_write(0, 1, 0, 60, 50, 5, 239);
        frame();
        check_pix(60, 59, 1, 2885, 0, "wrap");
        check_pix(69, 59, 1, 2894, 0, "wrap_r");
        cfg_write(3, 1, 0, 2, 2, 0, 0);
        frame();
        check_pix(3, 3, 0, 0, 0, "badidx");
        check_pix(60, 59, 1, 2885, 0, "badidx_keep");

        // Asynchronous reset while a hit is on the outputs.
        check_pix(60, 59, 1, 2885, 0, "prereset");
        #2 rst_n = 1'b0;
        #1;
        chk("arst_fs",   int'(frame_start), 0);
        chk("arst_hit",  int'(isObject),    0);
        chk("arst_addr", int'(pixel_addr),  0);
        chk("arst_id",   int'(obj_id),      0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        cfg_write(0, 1, 0, 70, 40, 320, 30);
        check_pix(70, 40, 0, 0, 0, "arst_nohit");
        frame();
        check_pix(70, 40, 1, 11120, 0, "arst_commit");

        for (int it = 0; it < 300; it++) begin
            int r, j, x, y;
            r = int'($urandom_range(0, 9));
            if (r < 2) begin
                cfg_write(int'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 3) == 0),
                          int'($urandom_range(0, 511)), int'($urandom_range(0, 511)),
                          int'($urandom_range(0, 359)), int'($urandom_range(0, 230)));
            end else if (r == 2) begin
                do_frame(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                         1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
                         int'($urandom_range(0, 511)), int'($urandom_range(0, 511)),
                         int'($urandom_range(0, 359)), int'($urandom_range(0, 230)));
            end else begin
                j = int'($urandom_range(0, N - 1));
                x = (m_act[j].x + int'($urandom_range(0, 13)) - 2 + 512) % 512;
                y = (m_act[j].y + int'($urandom_range(0, 13)) - 2 + 512) % 512;
                check_model(x, y, "rand");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
